// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - size encodings, FSM state type and lane helpers for dmem_ctrl
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lane[0];
            SZ_WORD: is_misaligned = |lane;
            SZ_RSVD: is_misaligned = 1'b1;
        endcase
    endfunction

    // Byte lanes touched by an access, little-endian by the low address bits.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << lane;
            SZ_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_mask = 4'b1111;
            SZ_RSVD: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - M-stage data memory request/response bus (parity_err with DMEM_PARITY_EN)
interface dmem_if;

    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        stall;
    logic        misalign;

`ifdef DMEM_PARITY_EN
    logic        parity_err;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  rdata, ack, stall, misalign, parity_err
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output rdata, ack, stall, misalign, parity_err
    );
`else
    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  rdata, ack, stall, misalign
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output rdata, ack, stall, misalign
    );
`endif

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array, byte-enable sync write, async read (parity bits with DMEM_PARITY_EN)
module dmem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
`ifdef DMEM_PARITY_EN
    ,
    output logic [3:0]        rpar
`endif
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

`ifdef DMEM_PARITY_EN
    // Even parity: stored bit makes the byte plus parity hold an even count of ones.
    logic [3:0] par [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                par[addr][i] <= ^wdata[8*i +: 8];
            end
        end
    end

    assign rpar = par[addr];
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - wait-state data memory controller with lane steering and load extension
// Optional per-byte parity checking is built when DMEM_PARITY_EN is defined.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic  CLK,
    input  logic  RST,
    dmem_if.slave bus
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
    localparam logic             HAS_WAIT  = (WAIT_CYCLES > 0);

    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic latch;

    logic              we_l, sx_l;
    logic [1:0]        size_l;
    logic [ADDR_W+1:0] addr_l;
    logic [31:0]       wdata_l;

    logic              we_c, sx_c;
    logic [1:0]        size_c;
    logic [ADDR_W+1:0] addr_c;

    logic [31:0] rdata_q;
    logic        mis_q;
    logic        ack_w;

    logic [31:0] word;
    logic [31:0] load_val;
    logic [31:0] wr_data;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [3:0]  be;
    logic        mis_c;

    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        latch    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    latch    = 1'b1;
                    cnt_nx   = WAIT_INIT;
                    state_nx = HAS_WAIT ? WAIT : ACK;
                end
            end
            WAIT: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = ACK;
                end
            end
            ACK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // In IDLE the request is still on the bus; a zero-wait access enters ACK
    // on the latching edge, so the result must be computed from the live inputs.
    always_comb begin
        if (state == IDLE) begin
            we_c   = bus.we;
            sx_c   = bus.sign_ext;
            size_c = bus.size;
            addr_c = bus.addr[ADDR_W+1:0];
        end else begin
            we_c   = we_l;
            sx_c   = sx_l;
            size_c = size_l;
            addr_c = addr_l;
        end
    end

    assign mis_c = is_misaligned(size_c, addr_c[1:0]);
    assign sel_b = word[{addr_c[1:0], 3'b000} +: 8];
    assign sel_h = addr_c[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_val = '0;
        case (size_c)
            SZ_BYTE: load_val = {{24{sx_c & sel_b[7]}}, sel_b};
            SZ_HALF: load_val = {{16{sx_c & sel_h[15]}}, sel_h};
            SZ_WORD: load_val = word;
            SZ_RSVD: load_val = '0;
        endcase
        if (mis_c || we_c) begin
            load_val = '0;
        end
    end

    always_comb begin
        wr_data = wdata_l;
        case (size_l)
            SZ_BYTE: wr_data = {4{wdata_l[7:0]}};
            SZ_HALF: wr_data = {2{wdata_l[15:0]}};
            default: wr_data = wdata_l;
        endcase
    end

    // The store commits on the edge leaving ACK; mis_q already holds this access's check.
    assign be = (state == ACK && we_l && !mis_q) ? lane_mask(size_l, addr_l[1:0]) : 4'b0000;

`ifdef DMEM_PARITY_EN
    logic [3:0] rpar;
    logic [3:0] lane_bad;
    logic       par_c;
    logic       par_q;

    always_comb begin
        lane_bad = '0;
        for (int i = 0; i < 4; i++) begin
            lane_bad[i] = (^word[8*i +: 8]) ^ rpar[i];
        end
    end

    assign par_c          = (|(lane_bad & lane_mask(size_c, addr_c[1:0]))) & ~mis_c & ~we_c;
    assign bus.parity_err = par_q;
`endif

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (CLK),
        .addr  (addr_c[ADDR_W+1:2]),
        .be    (be),
        .wdata (wr_data),
        .rdata (word)
`ifdef DMEM_PARITY_EN
        ,
        .rpar  (rpar)
`endif
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            cnt     <= '0;
            we_l    <= 1'b0;
            sx_l    <= 1'b0;
            size_l  <= SZ_BYTE;
            addr_l  <= '0;
            wdata_l <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
`ifdef DMEM_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (latch) begin
                we_l    <= bus.we;
                sx_l    <= bus.sign_ext;
                size_l  <= bus.size;
                addr_l  <= bus.addr[ADDR_W+1:0];
                wdata_l <= bus.wdata;
            end
            if (state_nx == ACK) begin
                rdata_q <= load_val;
                mis_q   <= mis_c;
`ifdef DMEM_PARITY_EN
                par_q   <= par_c;
`endif
            end
        end
    end

    assign ack_w        = (state == ACK);
    assign bus.ack      = ack_w;
    assign bus.stall    = bus.req & ~ack_w;
    assign bus.rdata    = rdata_q;
    assign bus.misalign = mis_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed vector bench for dmem_ctrl at WAIT_CYCLES 0, 3 and 5
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    logic [2:0]  t_req   = '0;
    logic        t_we    = 1'b0;
    logic        t_sx    = 1'b0;
    logic [1:0]  t_size  = SZ_WORD;
    logic [31:0] t_addr  = '0;
    logic [31:0] t_wdata = '0;

    logic [2:0]  ack_v, stall_v, mis_v, pe_v;
    logic [31:0] rd_v [3];

    int n_pass = 0;
    int n_tot  = 0;

    dmem_if b[3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 0 : (g == 1) ? 3 : 5;
        assign b[g].req      = t_req[g];
        assign b[g].we       = t_we;
        assign b[g].size     = t_size;
        assign b[g].sign_ext = t_sx;
        assign b[g].addr     = t_addr;
        assign b[g].wdata    = t_wdata;
        assign ack_v[g]      = b[g].ack;
        assign stall_v[g]    = b[g].stall;
        assign mis_v[g]      = b[g].misalign;
        assign rd_v[g]       = b[g].rdata;
`ifdef DMEM_PARITY_EN
        assign pe_v[g]       = b[g].parity_err;
`else
        assign pe_v[g]       = 1'b0;
`endif
        dmem_ctrl #(.ADDR_W(10), .WAIT_CYCLES(W)) u_dut (
            .CLK (CLK),
            .RST (RST),
            .bus (b[g])
        );
    end

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 5;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // One access: req asserted from a negedge, sampled 1ns after each rising edge.
    task automatic do_acc(input int d, input logic we, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic mis, output logic pe,
                          output int lat, output int stl);
        @(negedge CLK);
        t_we = we; t_size = sz; t_sx = sx; t_addr = a; t_wdata = wd;
        t_req[d] = 1'b1;
        lat = 0;
        stl = 0;
        #1;
        if (stall_v[d]) stl++;
        while (lat < 40) begin
            @(posedge CLK); #1;
            lat++;
            if (ack_v[d]) break;
            if (stall_v[d]) stl++;
        end
        rd  = rd_v[d];
        mis = mis_v[d];
        pe  = pe_v[d];
        t_req[d] = 1'b0;
        @(posedge CLK); #1;
    endtask

    typedef struct {
        int          d;
        logic        we;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
        logic        mis;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int d, input logic we, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input logic chk,
                       input logic [31:0] exp, input logic mis);
        vec_t v;
        v = '{d, we, sz, sx, a, wd, chk, exp, mis};
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        mis, pe;
        int          lat, stl, n_ack;

        add(0, 1, SZ_WORD, 0, 32'h10,   32'hDEADBEEF, 0, 32'h0,        0);
        add(0, 0, SZ_WORD, 0, 32'h10,   32'h0,        1, 32'hDEADBEEF, 0);
        add(1, 1, SZ_WORD, 0, 32'h10,   32'h80FF7F01, 0, 32'h0,        0);
        add(1, 0, SZ_BYTE, 1, 32'h13,   32'h0,        1, 32'hFFFFFF80, 0);
        add(1, 0, SZ_BYTE, 0, 32'h12,   32'h0,        1, 32'h000000FF, 0);
        add(1, 0, SZ_BYTE, 1, 32'h11,   32'h0,        1, 32'h0000007F, 0);
        add(1, 0, SZ_HALF, 1, 32'h12,   32'h0,        1, 32'hFFFF80FF, 0);
        add(1, 0, SZ_HALF, 1, 32'h10,   32'h0,        1, 32'h00007F01, 0);
        add(1, 1, SZ_WORD, 0, 32'h20,   32'h11223344, 0, 32'h0,        0);
        add(1, 1, SZ_HALF, 0, 32'h22,   32'h0000A5C3, 0, 32'h0,        0);
        add(1, 0, SZ_WORD, 0, 32'h20,   32'h0,        1, 32'hA5C33344, 0);
        add(1, 0, SZ_HALF, 1, 32'h22,   32'h0,        1, 32'hFFFFA5C3, 0);
        add(1, 0, SZ_HALF, 0, 32'h20,   32'h0,        1, 32'h00003344, 0);
        add(1, 0, SZ_WORD, 0, 32'h21,   32'h0,        1, 32'h0,        1);
        add(1, 1, SZ_HALF, 0, 32'h23,   32'h0000BEEF, 0, 32'h0,        1);
        add(1, 0, SZ_WORD, 0, 32'h20,   32'h0,        1, 32'hA5C33344, 0);
        add(1, 0, SZ_RSVD, 0, 32'h20,   32'h0,        1, 32'h0,        1);
        add(1, 1, SZ_RSVD, 0, 32'h20,   32'h0,        0, 32'h0,        1);
        add(1, 1, SZ_BYTE, 0, 32'h21,   32'hFFFFFF5A, 0, 32'h0,        0);
        add(1, 0, SZ_WORD, 0, 32'h20,   32'h0,        1, 32'hA5C35A44, 0);
        add(1, 0, SZ_WORD, 0, 32'h1020, 32'h0,        1, 32'hA5C35A44, 0);

        #2;
        check("reset ack",      {31'b0, ack_v[0]}, 32'h0);
        check("reset rdata",    rd_v[0],           32'h0);
        check("reset misalign", {31'b0, mis_v[0]}, 32'h0);
        check("reset stall",    {31'b0, stall_v[0]}, 32'h0);
        @(negedge CLK);
        RST = 1'b1;

        foreach (tbl[i]) begin
            do_acc(tbl[i].d, tbl[i].we, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].wd, rd, mis, pe, lat, stl);
            check($sformatf("v%0d latency", i), lat, wait_of(tbl[i].d) + 1);
            check($sformatf("v%0d stall cycles", i), stl, wait_of(tbl[i].d) + 1);
            check($sformatf("v%0d misalign", i), {31'b0, mis}, {31'b0, tbl[i].mis});
            if (tbl[i].chk) check($sformatf("v%0d rdata", i), rd, tbl[i].exp);
        end

        // req dropped after one cycle; operands scrambled while the access is in flight
        @(negedge CLK);
        t_we = 1'b1; t_size = SZ_WORD; t_sx = 1'b0; t_addr = 32'h40; t_wdata = 32'h00000077;
        t_req[1] = 1'b1;
        @(posedge CLK); #1;
        t_req[1] = 1'b0; t_addr = 32'h0; t_wdata = 32'hFFFFFFFF; t_we = 1'b0;
        lat = 1;
        while (!ack_v[1] && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        check("drop req latency", lat, 4);
        @(posedge CLK); #1;
        check("ack single cycle", {31'b0, ack_v[1]}, 32'h0);
        do_acc(1, 0, SZ_WORD, 0, 32'h40, 32'h0, rd, mis, pe, lat, stl);
        check("drop req store committed", rd, 32'h00000077);
        repeat (3) @(posedge CLK);
        #1;
        check("rdata held", rd_v[1], 32'h00000077);

        // reset in the middle of a 5-wait store
        do_acc(2, 1, SZ_WORD, 0, 32'h30, 32'h0BADF00D, rd, mis, pe, lat, stl);
        do_acc(2, 0, SZ_WORD, 0, 32'h30, 32'h0, rd, mis, pe, lat, stl);
        check("pre-reset load", rd, 32'h0BADF00D);
        @(negedge CLK);
        t_we = 1'b1; t_size = SZ_WORD; t_sx = 1'b0; t_addr = 32'h30; t_wdata = 32'hCAFEF00D;
        t_req[2] = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        t_req[2] = 1'b0;
        #1;
        check("mid reset ack",      {31'b0, ack_v[2]}, 32'h0);
        check("mid reset rdata",    rd_v[2],           32'h0);
        check("mid reset misalign", {31'b0, mis_v[2]}, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        n_ack = 0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (ack_v[2]) n_ack++;
        end
        check("no ack after reset", n_ack, 0);
        do_acc(2, 0, SZ_WORD, 0, 32'h30, 32'h0, rd, mis, pe, lat, stl);
        check("aborted store absent", rd, 32'h0BADF00D);

`ifdef DMEM_PARITY_EN
        do_acc(1, 1, SZ_WORD, 0, 32'h40, 32'h11223344, rd, mis, pe, lat, stl);
        g_dut[1].u_dut.u_array.mem[16][8] = ~g_dut[1].u_dut.u_array.mem[16][8];
        do_acc(1, 0, SZ_BYTE, 0, 32'h41, 32'h0, rd, mis, pe, lat, stl);
        check("parity bad lane flag", {31'b0, pe}, 32'h1);
        check("parity bad lane rdata", rd, 32'h00000032);
        do_acc(1, 0, SZ_BYTE, 0, 32'h40, 32'h0, rd, mis, pe, lat, stl);
        check("parity good lane flag", {31'b0, pe}, 32'h0);
        check("parity good lane rdata", rd, 32'h00000044);
        do_acc(1, 0, SZ_WORD, 0, 32'h41, 32'h0, rd, mis, pe, lat, stl);
        check("parity misaligned flag", {31'b0, pe}, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data-memory subsystem that replaces the single-cycle tristate word RAM on the pipelined CPU's memory stage. It has separate read and write buses and supports byte, halfword and word accesses with byte-enable writes and sign/zero extension on loads. A configurable wait-state FSM returns an ack and drives a stall to the pipeline. Misaligned accesses are detected and suppressed. It sits between the CPU's M-stage signals (ALUOutM, WriteDataM, MemWriteM) and the pipeline hazard unit.

Parameters:
ADDR_W, 10, word-address width; the array is 2^ADDR_W x 32-bit words and byte address bits [ADDR_W+1:0] are used.
WAIT_CYCLES, 0, extra wait states per access, 0..15.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous, active-low reset.
req  in  1  access request; held stable with its operands until ack.
we  in  1  1=store, 0=load.
size  in  2  00 byte, 01 half, 10 word, 11 reserved.
sign_ext  in  1  loads only: 1 sign-extends, 0 zero-extends.
addr  in  32  byte address.
wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
rdata  out  32  load result, extended; valid on the ack cycle and held until the next ack.
ack  out  1  one-cycle completion pulse.
stall  out  1  req & ~ack, combinational; freezes pipeline stages F to M.
misalign  out  1  valid with ack; the completed access was misaligned or reserved.

Behaviour:
- Reset (RST=0, async): FSM to IDLE; wait counter 0; rdata=0, ack=0, misalign=0; any pending store is dropped. Array contents are not reset.
- FSM states: IDLE, WAIT, ACK.
- IDLE: if req=1, latch we, size, sign_ext, addr and wdata. Load the counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, otherwise go to ACK.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to ACK on that edge.
- On entry to ACK (registered), compute rdata and misalign from the latched request.
- ACK: ack=1 for exactly one cycle. A store commits to the array on the edge leaving ACK. Next state is always IDLE.
- Latency: ack arrives WAIT_CYCLES+1 cycles after the cycle req is first seen in IDLE. Throughput is one access per WAIT_CYCLES+2 cycles. A req held high in the IDLE cycle after ACK is a new request.
- Alignment: a half with addr[0]=1, a word with addr[1:0]!=0, or size=11 sets misalign=1. In that case no array write occurs, rdata=0, and latency is unchanged.
- Byte lanes are little-endian by addr[1:0].
  - Byte store: write lane addr[1:0] with wdata[7:0].
  - Half store: write lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
- Loads: select the lane(s), then sign- or zero-extend to 32 bits. A word load ignores sign_ext.
- Address bits above ADDR_W+1 are ignored (aliasing); no range error is raised.
- If req drops before ack, the access still completes and commits; ack is still pulsed.
- Writes to an address do not affect a load that is already latched; there is no read-during-write hazard because only one access is in flight.

Optional Feature:
DMEM_PARITY_EN
- With the macro defined: store one even-parity bit per byte alongside the array, written with the byte. On a load, check the parity of the selected lanes. If any lane fails, assert the extra output parity_err (1 bit) with ack; rdata is still returned. A misaligned access never flags a parity error.
- Without the macro: no parity storage and no parity_err port.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - the FSM state typedef (IDLE, WAIT, ACK);
  - a 4-bit wait-counter width constant.
- Sub-module dmem_array: 2^ADDR_W x 32 storage with a 4-bit byte-enable synchronous write and an asynchronous read.
- The FSM, lane steering and extension stay in dmem_ctrl.

Test Plan:
- WAIT_CYCLES=0: sw 0xDEADBEEF @0x10, then lw @0x10 → first ack 1 cycle after req, lw rdata=0xDEADBEEF, misalign=0; stall high for exactly 1 cycle per access.
- WAIT_CYCLES=3: lb sign_ext=1 @0x13 after sw 0x80FF7F01 @0x10 → ack 4 cycles after req, rdata=0xFFFFFF80. Then lbu @0x12 → 0x000000FF.
- sh 0xA5C3 @0x22 over word 0x11223344 @0x20, then lw @0x20 → 0xA5C33344. lh sign_ext=1 @0x22 → 0xFFFFA5C3.
- Misaligned: lw @0x21 and sh @0x23 → misalign=1 with ack, rdata=0, and the word @0x20 is unchanged.
- Reset mid-access: WAIT_CYCLES=5, assert RST low 2 cycles into sw @0x30 → ack never pulses, the store is absent, and rdata/ack/misalign read 0 immediately.
- DMEM_PARITY_EN: force-flip one stored bit of byte 0x41 via backdoor, then lb @0x41 → parity_err=1 with ack; lb @0x40 → parity_err=0.
